// File: rtl/relu_vec_packer.sv
// relu_vec_packer: gathers per-lane activation results into full MEM_WIDTH words
// and writes them to the activation buffer at consecutive addresses.
module relu_vec_packer #(
  parameter int BUS_NUM          = 8,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int MEM_WIDTH        = BUS_NUM * FIXED_DATA_WIDTH,
  parameter int ADDR_WIDTH       = 10,
  parameter int CNT_WIDTH        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  vec_cnt,
  input  logic [MEM_WIDTH-1:0]  in_fixed_data,
  input  logic [BUS_NUM-1:0]    in_fixed_data_vld,
  output logic                  in_rdy,
  output logic                  mem_wr_vld,
  input  logic                  mem_wr_rdy,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [MEM_WIDTH-1:0]  mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int FW = FIXED_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } state_t;

  state_t               state;
  logic [BUS_NUM-1:0]   seen;
  logic [MEM_WIDTH-1:0] cap;
  logic [CNT_WIDTH-1:0] remaining;

  logic [BUS_NUM-1:0]   seen_next;
  logic [BUS_NUM-1:0]   fresh;
  logic [BUS_NUM-1:0]   dup;
  logic [BUS_NUM-1:0]   cap_en;
  logic [BUS_NUM-1:0]   seen_upd;
  logic [MEM_WIDTH-1:0] merged;
  logic                 full;
  logic                 out_free;
  logic                 hs;
  logic                 fire;
  logic                 last_vec;

  always_comb begin
    seen_next = seen | in_fixed_data_vld;
    fresh     = in_fixed_data_vld & ~seen;
    dup       = in_fixed_data_vld & seen;
    full      = &seen_next;
    hs        = mem_wr_vld & mem_wr_rdy;
    out_free  = ~mem_wr_vld | mem_wr_rdy;
    fire      = (state == COLLECT) & full & out_free;
    last_vec  = (remaining == CNT_WIDTH'(1));
    merged    = cap;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (fresh[i]) begin
        merged[i*FW +: FW] = in_fixed_data[i*FW +: FW];
      end
    end
    // lanes already seen are freed by a completing word and start the next one
    cap_en   = fire ? dup : fresh;
    seen_upd = fire ? dup : seen_next;
  end

  assign in_rdy = (state == COLLECT) & ~(&seen);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      seen        <= '0;
      cap         <= '0;
      remaining   <= '0;
      mem_wr_vld  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hs) begin
        mem_wr_addr <= mem_wr_addr + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            err  <= 1'b0;
            seen <= '0;
            if (vec_cnt != '0) begin
              mem_wr_addr <= base_addr;
              remaining   <= vec_cnt;
              state       <= COLLECT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        COLLECT: begin
          seen <= seen_upd;
          for (int i = 0; i < BUS_NUM; i++) begin
            if (cap_en[i]) begin
              cap[i*FW +: FW] <= in_fixed_data[i*FW +: FW];
            end
          end
          if (fire) begin
            mem_wr_data <= merged;
            mem_wr_vld  <= 1'b1;
            remaining   <= remaining - 1'b1;
            if (last_vec) begin
              state <= FLUSH;
            end
          end else begin
            if (hs) begin
              mem_wr_vld <= 1'b0;
            end
            if (|dup) begin
              err <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (|in_fixed_data_vld) begin
            err <= 1'b1;
          end
          if (hs) begin
            mem_wr_vld <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_vec_packer.sv
// Bench for relu_vec_packer: directed scenarios plus randomized lane arrival
// against a word/address list model.
module tb_relu_vec_packer;

  localparam int BN = 8;
  localparam int FW = 8;
  localparam int MW = BN * FW;
  localparam int AW = 10;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] vec_cnt = '0;
  logic [MW-1:0] in_fixed_data = '0;
  logic [BN-1:0] in_fixed_data_vld = '0;
  logic          in_rdy;
  logic          mem_wr_vld;
  logic          mem_wr_rdy = 1'b0;
  logic [AW-1:0] mem_wr_addr;
  logic [MW-1:0] mem_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad = 0;

  logic [AW+MW-1:0] obs_q[$];

  relu_vec_packer #(
    .BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .MEM_WIDTH(MW),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .vec_cnt(vec_cnt),
    .in_fixed_data(in_fixed_data),
    .in_fixed_data_vld(in_fixed_data_vld),
    .in_rdy(in_rdy), .mem_wr_vld(mem_wr_vld),
    .mem_wr_rdy(mem_wr_rdy), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_wr_vld && mem_wr_rdy) begin
      obs_q.push_back({mem_wr_addr, mem_wr_data});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [CW-1:0] n);
    base_addr = b;
    vec_cnt = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [MW-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy got=%b exp=0", in_rdy); end
    total++; if (mem_wr_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", mem_wr_vld); end
    total++; if (mem_wr_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_wr_addr); end
    total++; if (mem_wr_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", mem_wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [MW-1:0] d;
    d = rnd_word();
    obs_q.delete();
    mem_wr_rdy = 1'b1;
    launch(10'h010, 10'd1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL single_in_rdy got=%b exp=1", in_rdy); end
    in_fixed_data = d;
    in_fixed_data_vld = '1;
    step();
    in_fixed_data_vld = '0;
    total++; if (mem_wr_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=1", mem_wr_vld); end
    total++; if (mem_wr_addr !== 10'h010) begin bad++; $display("FAIL single_addr got=%h exp=010", mem_wr_addr); end
    total++; if (mem_wr_data !== d) begin bad++; $display("FAIL single_data got=%h exp=%h", mem_wr_data, d); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    total++; if (mem_wr_vld !== 1'b0) begin bad++; $display("FAIL single_vld_end got=%b exp=0", mem_wr_vld); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_writes got=%0d exp=1", obs_q.size()); end
  endtask

  task automatic test_split();
    logic [MW-1:0] lo, hi, e;
    bit ok;
    lo = rnd_word();
    hi = rnd_word();
    e = {hi[MW-1:MW/2], lo[MW/2-1:0]};
    mem_wr_rdy = 1'b1;
    launch(10'h040, 10'd1);
    in_fixed_data = lo;
    in_fixed_data_vld = 8'h0F;
    step();
    in_fixed_data_vld = '0;
    in_fixed_data = rnd_word();
    for (int c = 0; c < 3; c++) begin
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL split_in_rdy c=%0d got=%b exp=1", c, in_rdy); end
      total++; if (mem_wr_vld !== 1'b0) begin bad++; $display("FAIL split_early_vld c=%0d got=%b exp=0", c, mem_wr_vld); end
      if (c < 2) step();
    end
    in_fixed_data = hi;
    in_fixed_data_vld = 8'hF0;
    step();
    in_fixed_data_vld = '0;
    total++; if (mem_wr_vld !== 1'b1) begin bad++; $display("FAIL split_vld got=%b exp=1", mem_wr_vld); end
    total++; if (mem_wr_data !== e) begin bad++; $display("FAIL split_data got=%h exp=%h", mem_wr_data, e); end
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL split_done got=0 exp=1"); end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] a, b, c;
    logic [AW-1:0] base;
    bit ok;
    a = rnd_word();
    b = rnd_word();
    c = rnd_word();
    base = 10'h120;
    obs_q.delete();
    mem_wr_rdy = 1'b0;
    launch(base, 10'd3);
    in_fixed_data = a;
    in_fixed_data_vld = '1;
    step();
    in_fixed_data = b;
    step();
    in_fixed_data_vld = '0;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL b2b_stall_rdy got=%b exp=0", in_rdy); end
    for (int k = 0; k < 3; k++) begin
      total++; if (mem_wr_data !== a) begin bad++; $display("FAIL b2b_hold_data k=%0d got=%h exp=%h", k, mem_wr_data, a); end
      total++; if (mem_wr_addr !== base) begin bad++; $display("FAIL b2b_hold_addr k=%0d got=%h exp=%h", k, mem_wr_addr, base); end
      step();
    end
    mem_wr_rdy = 1'b1;
    step();
    total++; if (mem_wr_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld got=%b exp=1", mem_wr_vld); end
    total++; if (mem_wr_addr !== base + 10'd1) begin bad++; $display("FAIL b2b_addr1 got=%h exp=%h", mem_wr_addr, base + 10'd1); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy_back got=%b exp=1", in_rdy); end
    in_fixed_data = c;
    in_fixed_data_vld = '1;
    step();
    in_fixed_data_vld = '0;
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done got=0 exp=1"); end
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      total++; if (obs_q[0] !== {base, a}) begin bad++; $display("FAIL b2b_w0 got=%h exp=%h", obs_q[0], {base, a}); end
      total++; if (obs_q[1] !== {base + 10'd1, b}) begin bad++; $display("FAIL b2b_w1 got=%h exp=%h", obs_q[1], {base + 10'd1, b}); end
      total++; if (obs_q[2] !== {base + 10'd2, c}) begin bad++; $display("FAIL b2b_w2 got=%h exp=%h", obs_q[2], {base + 10'd2, c}); end
    end
  endtask

  task automatic test_err();
    logic [FW-1:0] v1, v2;
    logic [MW-1:0] w, e;
    bit ok;
    v1 = FW'($urandom);
    v2 = v1 ^ 8'h5A;
    w = rnd_word();
    e = w;
    e[2*FW +: FW] = v1;
    mem_wr_rdy = 1'b1;
    launch(10'h080, 10'd1);
    in_fixed_data = rnd_word();
    in_fixed_data[2*FW +: FW] = v1;
    in_fixed_data_vld = 8'h04;
    step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_first got=%b exp=0", err); end
    in_fixed_data[2*FW +: FW] = v2;
    step();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_dup got=%b exp=1", err); end
    in_fixed_data = w;
    in_fixed_data_vld = 8'hFB;
    step();
    in_fixed_data_vld = '0;
    total++; if (mem_wr_data !== e) begin bad++; $display("FAIL err_keep_first got=%h exp=%h", mem_wr_data, e); end
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_done got=0 exp=1"); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    launch(10'h081, 10'd1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    in_fixed_data_vld = '1;
    step();
    in_fixed_data_vld = '0;
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_done2 got=0 exp=1"); end
  endtask

  task automatic test_wrap();
    logic [MW-1:0] a, b;
    bit ok;
    a = rnd_word();
    b = rnd_word();
    obs_q.delete();
    mem_wr_rdy = 1'b1;
    launch(10'h3FF, 10'd2);
    in_fixed_data = a;
    in_fixed_data_vld = '1;
    step();
    in_fixed_data = b;
    step();
    in_fixed_data_vld = '0;
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_done got=0 exp=1"); end
    total++; if (obs_q.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0] !== {10'h3FF, a}) begin bad++; $display("FAIL wrap_w0 got=%h exp=%h", obs_q[0], {10'h3FF, a}); end
      total++; if (obs_q[1] !== {10'h000, b}) begin bad++; $display("FAIL wrap_w1 got=%h exp=%h", obs_q[1], {10'h000, b}); end
    end
  endtask

  task automatic test_reset_mid();
    obs_q.delete();
    mem_wr_rdy = 1'b0;
    launch(10'h055, 10'd8);
    in_fixed_data = rnd_word();
    in_fixed_data_vld = '1;
    step();
    in_fixed_data = rnd_word();
    in_fixed_data_vld = 8'h1F;
    step();
    in_fixed_data_vld = '0;
    total++; if (mem_wr_vld !== 1'b1) begin bad++; $display("FAIL mid_pre_vld got=%b exp=1", mem_wr_vld); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL mid_pre_rdy got=%b exp=1", in_rdy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (mem_wr_vld !== 1'b0) begin bad++; $display("FAIL mid_vld got=%b exp=0", mem_wr_vld); end
    total++; if (mem_wr_data !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", mem_wr_data); end
    total++; if (mem_wr_addr !== '0) begin bad++; $display("FAIL mid_addr got=%h exp=0", mem_wr_addr); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL mid_in_rdy got=%b exp=0", in_rdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    step();
    rst = 1'b0;
    mem_wr_rdy = 1'b1;
    in_fixed_data_vld = '1;
    for (int k = 0; k < 4; k++) begin
      in_fixed_data = rnd_word();
      step();
    end
    in_fixed_data_vld = '0;
    total++; if (mem_wr_vld !== 1'b0) begin bad++; $display("FAIL post_rst_vld got=%b exp=0", mem_wr_vld); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%b exp=0", err); end
    launch(10'h0AA, 10'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [MW-1:0] exp_w[8];
    logic [MW-1:0] d;
    logic [BN-1:0] sent, m;
    logic [AW-1:0] b, ea;
    int n, k;
    bit ok;
    for (int run = 0; run < 6; run++) begin
      n = $urandom_range(1, 6);
      b = AW'($urandom_range(0, 1023));
      for (int i = 0; i < 8; i++) exp_w[i] = '0;
      obs_q.delete();
      k = 0;
      sent = '0;
      ok = 1'b0;
      launch(b, CW'(n));
      for (int cyc = 0; cyc < 600; cyc++) begin
        mem_wr_rdy = ($urandom_range(0, 3) != 0);
        in_fixed_data_vld = '0;
        if (k < n && in_rdy) begin
          d = rnd_word();
          m = BN'($urandom) & ~sent;
          for (int l = 0; l < BN; l++) begin
            if (m[l]) exp_w[k][l*FW +: FW] = d[l*FW +: FW];
          end
          in_fixed_data = d;
          in_fixed_data_vld = m;
          sent = sent | m;
          if (&sent) begin
            k++;
            sent = '0;
          end
        end
        step();
        if (done) begin
          ok = 1'b1;
          break;
        end
      end
      in_fixed_data_vld = '0;
      total++; if (!ok) begin bad++; $display("FAIL rnd_done run=%0d got=0 exp=1", run); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err run=%0d got=%b exp=0", run, err); end
      total++; if (obs_q.size() != n) begin bad++; $display("FAIL rnd_count run=%0d got=%0d exp=%0d", run, obs_q.size(), n); end
      for (int i = 0; i < n && i < obs_q.size(); i++) begin
        ea = b + AW'(i);
        total++;
        if (obs_q[i] !== {ea, exp_w[i]}) begin
          bad++;
          $display("FAIL rnd_word run=%0d i=%0d got=%h exp=%h", run, i, obs_q[i], {ea, exp_w[i]});
        end
      end
    end
    mem_wr_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_back_to_back();
    test_err();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
